alu_issue_unit: RTL and testbench

- Upstream stage of the 8-bit ALU.
- Accepts 3-address instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's A/B/opcode inputs from registers, captures the ALU's combinational result, and writes it back to the register file.
- Reports each completed result on a one-cycle result strobe. Opcode 3'b111 is repurposed here as load-immediate.

---
 rtl/alu_issue_unit.sv | 91 +++++++++
 tb/tb_alu_issue_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Issue stage feeding an 8-bit combinational ALU: reads operands from a small register
// file, presents them to the ALU for one cycle, writes the result back and reports it.
module alu_issue_unit #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [REG_AW-1:0] instr_dst,
   input  logic [REG_AW-1:0] instr_srca,
   input  logic [REG_AW-1:0] instr_srcb,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic [REG_AW-1:0] res_dst,
   output logic              res_zero,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NREG = 2 ** REG_AW;
   localparam logic [2:0] OP_LDI = 3'b111;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EXEC  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]        state;
   logic [REG_AW-1:0] dst_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] wb;
   logic [DATA_W-1:0] regfile [NREG];

   assign instr_ready = (state == IDLE);
   assign res_valid   = (state == WRITE);
   assign dbg_data    = regfile[dbg_addr];

   // alu_op doubles as the latched opcode, so LDI is recognised from it directly.
   assign wb = (alu_op == OP_LDI) ? imm_q : alu_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         dst_q    <= '0;
         imm_q    <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= OP_LDI;
         res_data <= '0;
         res_dst  <= '0;
         res_zero <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regfile[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  dst_q  <= instr_dst;
                  imm_q  <= instr_imm;
                  alu_a  <= regfile[instr_srca];
                  alu_b  <= regfile[instr_srcb];
                  alu_op <= instr_op;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               regfile[dst_q] <= wb;
               res_data       <= wb;
               res_dst        <= dst_q;
               res_zero       <= (wb == '0);
               state          <= WRITE;
            end
            WRITE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural 8-bit ALU attached to its operand ports.
module tb_alu_issue_unit;

   localparam logic [2:0] OP_INV = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_LDI = 3'b111;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [1:0] instr_dst;
   logic [1:0] instr_srca;
   logic [1:0] instr_srcb;
   logic [7:0] instr_imm;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       res_valid;
   logic [7:0] res_data;
   logic [1:0] res_dst;
   logic       res_zero;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   int check_count = 0;
   int pass_count  = 0;

   alu_issue_unit #(.DATA_W(8), .REG_AW(2)) dut (
      .clk(clk),
      .rst(rst),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_op(instr_op),
      .instr_dst(instr_dst),
      .instr_srca(instr_srca),
      .instr_srcb(instr_srcb),
      .instr_imm(instr_imm),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_op(alu_op),
      .alu_result(alu_result),
      .res_valid(res_valid),
      .res_data(res_data),
      .res_dst(res_dst),
      .res_zero(res_zero),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; opcodes 001/011 are not exercised and just return AND/OR.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         3'b000:  alu_result = ~alu_a;
         3'b001:  alu_result = alu_a & alu_b;
         3'b010:  alu_result = alu_a ^ alu_b;
         3'b011:  alu_result = alu_a | alu_b;
         3'b100:  alu_result = alu_a * alu_b;
         3'b101:  alu_result = alu_a + alu_b;
         3'b110:  alu_result = alu_a - alu_b;
         default: alu_result = '0;
      endcase
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction and returns #1 after the accept edge, i.e. in the EXEC cycle.
   task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [7:0] imm);
      bit accepted;
      accepted    = 1'b0;
      instr_op    = op;
      instr_dst   = dst;
      instr_srca  = sa;
      instr_srcb  = sb;
      instr_imm   = imm;
      instr_valid = 1'b1;
      for (int i = 0; i < 10 && !accepted; i++) begin
         accepted = instr_ready;
         step();
      end
      instr_valid = 1'b0;
      check_count++;
      if (accepted !== 1'b1)
         $display("[TB] FAIL handshake_timeout: accepted=%0b required=1", accepted);
      else
         pass_count++;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      instr_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i);
         #1;
         check_count++;
         if (dbg_data !== 8'h00)
            $display("[TB] FAIL reset_regfile[%0d]: got %h required 00", i, dbg_data);
         else
            pass_count++;
      end
      check_count++;
      if (instr_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b required 1", instr_ready);
      else pass_count++;
      check_count++;
      if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid);
      else pass_count++;
      check_count++;
      if (alu_op !== OP_LDI) $display("[TB] FAIL reset_alu_op: got %b required 111", alu_op);
      else pass_count++;
      check_count++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00)
         $display("[TB] FAIL reset_alu_ab: got %h/%h required 00/00", alu_a, alu_b);
      else pass_count++;
   endtask

   task automatic test_ldi_add();
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05);
      step();
      check_count++;
      if (res_valid !== 1'b1 || res_data !== 8'h05 || res_dst !== 2'd1)
         $display("[TB] FAIL ldi_r1: got v=%b d=%h dst=%0d required v=1 d=05 dst=1", res_valid, res_data, res_dst);
      else pass_count++;
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03);
      step();
      check_count++;
      if (res_valid !== 1'b1 || res_data !== 8'h03 || res_dst !== 2'd2)
         $display("[TB] FAIL ldi_r2: got v=%b d=%h dst=%0d required v=1 d=03 dst=2", res_valid, res_data, res_dst);
      else pass_count++;
      issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'hAA);
      check_count++;
      if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== OP_ADD || instr_ready !== 1'b0 || res_valid !== 1'b0)
         $display("[TB] FAIL add_exec: got a=%h b=%h op=%b rdy=%b v=%b required a=05 b=03 op=101 rdy=0 v=0",
                  alu_a, alu_b, alu_op, instr_ready, res_valid);
      else pass_count++;
      step();
      check_count++;
      if (res_valid !== 1'b1 || res_data !== 8'h08 || res_dst !== 2'd3 || res_zero !== 1'b0 || instr_ready !== 1'b0)
         $display("[TB] FAIL add_write: got v=%b d=%h dst=%0d z=%b rdy=%b required v=1 d=08 dst=3 z=0 rdy=0",
                  res_valid, res_data, res_dst, res_zero, instr_ready);
      else pass_count++;
      dbg_addr = 2'd3;
      step();
      check_count++;
      if (res_valid !== 1'b0 || res_data !== 8'h08 || res_dst !== 2'd3 || dbg_data !== 8'h08)
         $display("[TB] FAIL add_hold: got v=%b d=%h dst=%0d r3=%h required v=0 d=08 dst=3 r3=08",
                  res_valid, res_data, res_dst, dbg_data);
      else pass_count++;
   endtask

   task automatic test_wrap_zero();
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF);
      step();
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01);
      step();
      issue(OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00);
      step();
      check_count++;
      if (res_data !== 8'h00 || res_zero !== 1'b1 || res_dst !== 2'd3)
         $display("[TB] FAIL add_wrap: got d=%h z=%b dst=%0d required d=00 z=1 dst=3", res_data, res_zero, res_dst);
      else pass_count++;
      issue(OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00);
      step();
      check_count++;
      if (res_data !== 8'h02 || res_zero !== 1'b0 || res_dst !== 2'd0)
         $display("[TB] FAIL sub_wrap: got d=%h z=%b dst=%0d required d=02 z=0 dst=0", res_data, res_zero, res_dst);
      else pass_count++;
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h10);
      step();
      issue(OP_MUL, 2'd2, 2'd1, 2'd1, 8'h00);
      step();
      dbg_addr = 2'd2;
      #1;
      check_count++;
      if (res_data !== 8'h00 || res_zero !== 1'b1 || dbg_data !== 8'h00)
         $display("[TB] FAIL mul_wrap: got d=%h z=%b r2=%h required d=00 z=1 r2=00", res_data, res_zero, dbg_data);
      else pass_count++;
      step();
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops  [3] = '{OP_LDI, OP_LDI, OP_ADD};
      logic [1:0] dsts [3] = '{2'd0, 2'd1, 2'd2};
      logic [7:0] imms [3] = '{8'h11, 8'h22, 8'h00};
      int accept_cycle [3];
      int k = 0;
      int pulses = 0;
      int busy = 0;
      bit rdy;
      instr_op    = ops[0];
      instr_dst   = dsts[0];
      instr_srca  = 2'd0;
      instr_srcb  = 2'd1;
      instr_imm   = imms[0];
      instr_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         rdy = instr_ready;
         if (res_valid === 1'b1) pulses++;
         if (rdy !== 1'b1) busy++;
         @(posedge clk);
         if (rdy && instr_valid && k < 3) begin
            accept_cycle[k] = c;
            k++;
         end
         #1;
         if (k < 3) begin
            instr_op  = ops[k];
            instr_dst = dsts[k];
            instr_imm = imms[k];
         end else begin
            instr_valid = 1'b0;
         end
      end
      instr_valid = 1'b0;
      check_count++;
      if (k !== 3 || accept_cycle[1] - accept_cycle[0] !== 3 || accept_cycle[2] - accept_cycle[1] !== 3)
         $display("[TB] FAIL b2b_spacing: got n=%0d cycles %0d,%0d,%0d required n=3 spacing 3",
                  k, accept_cycle[0], accept_cycle[1], accept_cycle[2]);
      else pass_count++;
      check_count++;
      if (pulses !== 3) $display("[TB] FAIL b2b_pulses: got %0d required 3", pulses);
      else pass_count++;
      check_count++;
      if (busy !== 6) $display("[TB] FAIL b2b_not_ready: got %0d required 6", busy);
      else pass_count++;
      dbg_addr = 2'd2;
      #1;
      check_count++;
      if (dbg_data !== 8'h33 || res_data !== 8'h33)
         $display("[TB] FAIL b2b_result: got r2=%h d=%h required 33/33", dbg_data, res_data);
      else pass_count++;
   endtask

   task automatic test_alias();
      issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h07);
      step();
      issue(OP_XOR, 2'd1, 2'd1, 2'd1, 8'h00);
      check_count++;
      if (alu_a !== 8'h07 || alu_b !== 8'h07)
         $display("[TB] FAIL alias_operands: got %h/%h required 07/07", alu_a, alu_b);
      else pass_count++;
      step();
      dbg_addr = 2'd1;
      #1;
      check_count++;
      if (res_data !== 8'h00 || res_zero !== 1'b1 || dbg_data !== 8'h00)
         $display("[TB] FAIL alias_xor: got d=%h z=%b r1=%h required d=00 z=1 r1=00", res_data, res_zero, dbg_data);
      else pass_count++;
      issue(OP_INV, 2'd1, 2'd1, 2'd1, 8'h00);
      step();
      #1;
      check_count++;
      if (res_data !== 8'hFF || res_zero !== 1'b0 || dbg_data !== 8'hFF)
         $display("[TB] FAIL alias_inv: got d=%h z=%b r1=%h required d=FF z=0 r1=FF", res_data, res_zero, dbg_data);
      else pass_count++;
   endtask

   task automatic test_reset_mid_op();
      issue(OP_ADD, 2'd3, 2'd1, 2'd1, 8'h00);
      rst = 1'b1;
      step();
      rst      = 1'b0;
      dbg_addr = 2'd3;
      #1;
      check_count++;
      if (res_valid !== 1'b0 || instr_ready !== 1'b1 || dbg_data !== 8'h00)
         $display("[TB] FAIL midreset_state: got v=%b rdy=%b r3=%h required v=0 rdy=1 r3=00",
                  res_valid, instr_ready, dbg_data);
      else pass_count++;
      dbg_addr = 2'd1;
      step();
      check_count++;
      if (res_valid !== 1'b0 || dbg_data !== 8'h00 || res_data !== 8'h00)
         $display("[TB] FAIL midreset_cleared: got v=%b r1=%h d=%h required v=0 r1=00 d=00",
                  res_valid, dbg_data, res_data);
      else pass_count++;
      issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h5A);
      step();
      check_count++;
      if (res_valid !== 1'b1 || res_data !== 8'h5A || res_dst !== 2'd2)
         $display("[TB] FAIL midreset_recover: got v=%b d=%h dst=%0d required v=1 d=5A dst=2",
                  res_valid, res_data, res_dst);
      else pass_count++;
      step();
   endtask

   initial begin
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr_op    = 3'b000;
      instr_dst   = 2'd0;
      instr_srca  = 2'd0;
      instr_srcb  = 2'd0;
      instr_imm   = 8'h00;
      dbg_addr    = 2'd0;
      #1;
      $display("[TB] starting alu_issue_unit directed tests");
      test_reset();
      test_ldi_add();
      test_wrap_zero();
      test_back_to_back();
      test_alias();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
